// File: rtl/seq_pattern_counter.sv
// Serial pattern detector with a saturating event counter and a runtime-loadable pattern.
// Define SEQ_PATTERN_CNT_BCD_EN to add the registered 4-digit BCD view of the count (o_bcd).
module seq_pattern_counter #(
  parameter int               PAT_W    = 4,
  parameter int               CNT_W    = 8,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b0101
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_overlap,
  input  logic [PAT_W-1:0] i_pat,
  input  logic             i_pat_load,
  input  logic             i_clr,
  output logic             o_det,
  output logic [CNT_W-1:0] o_cnt,
`ifdef SEQ_PATTERN_CNT_BCD_EN
  output logic [15:0]      o_bcd,
`endif
  output logic             o_of
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              of_q, of_d;
  logic              det_q;
  logic [PAT_W-1:0]  window;
  logic              match;

  // Candidate window: history plus the incoming bit, oldest bit at the MSB.
  assign window = {hist_q, i_bit};
  assign match  = i_valid && !i_pat_load && (window == pat_q) && (fill_q == FILL_MAX);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (i_pat_load) begin
      pat_d  = i_pat;
      hist_d = '0;
      fill_d = '0;
    end else if (i_valid) begin
      hist_d = window[PAT_W-2:0];
      if (match && !i_overlap)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    of_d  = of_q;
    if (i_clr) begin
      cnt_d = '0;
      of_d  = 1'b0;
    end else if (match) begin
      if (cnt_q == CNT_MAX) of_d  = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      of_q   <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      of_q   <= of_d;
      det_q  <= match;
    end
  end

  assign o_det = det_q;
  assign o_cnt = cnt_q;
  assign o_of  = of_q;

`ifdef SEQ_PATTERN_CNT_BCD_EN
  generate
    if (CNT_W > 13) begin : g_cnt_w_chk
      $error("seq_pattern_counter: CNT_W must be <= 13 when BCD output is enabled");
    end
  endgenerate

  logic [15:0] bcd_q, bcd_d;

  // Double-dabble on the registered count, so o_bcd trails o_cnt by one cycle.
  always_comb begin
    bcd_d = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 4; d++)
        if (bcd_d[d*4 +: 4] >= 4'd5) bcd_d[d*4 +: 4] = bcd_d[d*4 +: 4] + 4'd3;
      bcd_d = {bcd_d[14:0], cnt_q[i]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign o_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench for seq_pattern_counter (PAT_W=4, CNT_W=4): vector table plus hand-written corner sequences.
module tb_seq_pattern_counter;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_bit = 1'b0;
  logic             i_overlap = 1'b0;
  logic [PAT_W-1:0] i_pat = '0;
  logic             i_pat_load = 1'b0;
  logic             i_clr = 1'b0;
  logic             o_det;
  logic [CNT_W-1:0] o_cnt;
  logic             o_of;
`ifdef SEQ_PATTERN_CNT_BCD_EN
  logic [15:0]      o_bcd;
`endif

  seq_pattern_counter #(.PAT_W(PAT_W), .CNT_W(CNT_W), .PAT_INIT(4'b0101)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_bit(i_bit),
    .i_overlap(i_overlap), .i_pat(i_pat), .i_pat_load(i_pat_load), .i_clr(i_clr),
    .o_det(o_det), .o_cnt(o_cnt),
`ifdef SEQ_PATTERN_CNT_BCD_EN
    .o_bcd(o_bcd),
`endif
    .o_of(o_of)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic             rst, valid, bit_v, ovl, load, clr;
    logic [PAT_W-1:0] pat;
    logic             det;
    int               cnt;
    logic             of;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int prev_cnt = 0;

  function automatic vec_t mk(input logic rst, valid, bit_v, ovl, load, input logic [PAT_W-1:0] pat,
                              input logic clr, det, input int cnt, input logic of);
    vec_t v;
    v.rst = rst; v.valid = valid; v.bit_v = bit_v; v.ovl = ovl; v.load = load;
    v.pat = pat; v.clr = clr; v.det = det; v.cnt = cnt; v.of = of;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    i_rst = v.rst; i_valid = v.valid; i_bit = v.bit_v; i_overlap = v.ovl;
    i_pat_load = v.load; i_pat = v.pat; i_clr = v.clr;
    @(posedge i_clk);
    #1;
    total++;
    if (o_det !== v.det) begin
      bad++; $display("FAIL %s det: got %b want %b", name, o_det, v.det);
    end
    total++;
    if (o_cnt !== CNT_W'(v.cnt)) begin
      bad++; $display("FAIL %s cnt: got %0d want %0d", name, o_cnt, v.cnt);
    end
    total++;
    if (o_of !== v.of) begin
      bad++; $display("FAIL %s of: got %b want %b", name, o_of, v.of);
    end
`ifdef SEQ_PATTERN_CNT_BCD_EN
    begin
      logic [15:0] eb;
      eb = v.rst ? 16'h0 : {4'(prev_cnt / 1000), 4'((prev_cnt / 100) % 10),
                            4'((prev_cnt / 10) % 10), 4'(prev_cnt % 10)};
      total++;
      if (o_bcd !== eb) begin
        bad++; $display("FAIL %s bcd: got %h want %h", name, o_bcd, eb);
      end
    end
`endif
    prev_cnt = v.cnt;
  endtask

  vec_t tbl[$];

  initial begin
    // rst vld bit ovl load pat clr | det cnt of
    tbl.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0));  // reset
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0));  // overlap 0,1,0,1,0,1
    tbl.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'h5, 0, 0, 2, 0));  // flush via reload 0101
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 2, 0));  // non-overlap 0,1,0,1,0,1
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4'h5, 0, 0, 3, 0));  // gaps between 0,1,0,1
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 1, 4, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 4'hC, 0, 0, 4, 0));  // load 1100, same-cycle bit dropped
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 4, 0));  // would match if dropped bit were kept
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 5, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 5, 0));  // clear collides with match
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0, 5, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 5, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Saturation: pattern 0000 in overlap mode matches on every zero once fill saturates.
    step(mk(0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0), "sat_load");
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0), $sformatf("sat_fill%0d", i));
    for (int k = 1; k <= 15; k++) step(mk(0, 1, 0, 1, 0, 4'h0, 0, 1, k, 0), $sformatf("sat_m%0d", k));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 1, 15, 1), "sat_m16");
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 1, 15, 1), "sat_m17");
    step(mk(0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 0), "sat_clr");
    step(mk(0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0), "sat_idle");

    // Reset with random stimulus, then a partial match lost to a mid-stream reset.
    for (int i = 0; i < 2; i++)
      step(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              1'($urandom), 0, 0, 0), $sformatf("rst%0d", i));
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0), "mid_b0");
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0), "mid_b1");
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0), "mid_b2");
    step(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0), "mid_rst");
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0), "mid_lost");
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0), "init_b0");
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0), "init_b1");
    step(mk(0, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0), "init_b2");
    step(mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 1, 0), "init_match");
    step(mk(0, 0, 0, 1, 0, 4'h0, 0, 0, 1, 0), "init_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
